sort_arbiter: RTL and testbench
===============================

// Module: sort_arbiter
// PURPOSE
//  Shares one bubble-sort core among NUM_REQ requesters and sequences each job through four phases:
//  clear, load NUM_DATA words, sort, drain NUM_DATA sorted words.
//  Requesters are granted in round-robin order. Jobs run one at a time, with no overlap.
//  Sits between the requester streams and the sorter's wr_en/rd_en/done/dataout pins.
// PARAMETERS
//  DATA_WIDTH    8    word width
//  NUM_DATA      8    words per job (>=2)
//  NUM_REQ       4    requesters (>=2)
//  SORT_TIMEOUT  128  max SORT-state cycles before abort
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   reset, asynchronous, active-high
//  req          in   NUM_REQ             per-requester job request (level)
//  grant        out  NUM_REQ             one-hot owner of the current job
//  in_valid     in   NUM_REQ             per-requester load-data valid
//  in_data      in   NUM_REQ*DATA_WIDTH  packed load data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//  in_ready     out  NUM_REQ             load-data ready; only grant[k] bit may be 1
//  out_valid    out  1                   sorted word valid; no backpressure, consumer must take it
//  out_data     out  DATA_WIDTH          sorted word, ascending
//  out_last     out  1                   marks the final word of a job
//  out_id       out  $clog2(NUM_REQ)     index of the requester that owns the output
//  busy         out  1                   state != IDLE
//  err          out  1                   one-cycle pulse when a sort times out
//  srt_rst      out  1                   sorter sync clear; high while rst is high or state == CLR
//  srt_wr_en    out  1                   sorter write strobe
//  srt_datain   out  DATA_WIDTH          sorter write data
//  srt_rd_en    out  1                   sorter sort-step enable
//  srt_dataout  in   DATA_WIDTH          sorter drain data; registered, one word per cycle after done
//  srt_done     in   1                   sorter sort complete; low after srt_rst
// BEHAVIOUR
//  Reset: all outputs 0 except srt_rst = 1 while rst is high. state = IDLE, rr_ptr = 0, counters = 0.
//  A reset asserted mid-job aborts the job immediately. No partial output follows the abort.
//  IDLE
//   - If req != 0: grant the first k with req[k] = 1, searching from rr_ptr upward with wrap.
//   - grant registers on that edge. Go to CLR.
//  CLR: one cycle, srt_rst = 1. Then go to LOAD.
//  LOAD
//   - in_ready = grant. A beat is in_valid[g] & in_ready[g].
//   - Each beat: srt_wr_en = 1, srt_datain = slice g (both combinational), cnt++.
//   - The edge of beat NUM_DATA goes to SORT with cnt = 0. Gaps (in_valid low) are allowed and stall the load.
//  SORT
//   - srt_rd_en = ~srt_done (combinational). tcnt increments each cycle.
//   - srt_done sampled 1: go to DRAIN. The sorter registers word 0 on that same edge.
//   - tcnt == SORT_TIMEOUT-1 with srt_done still 0: err = 1 for one cycle, go to IDLE.
//     rr_ptr advances. No output is produced.
//  DRAIN
//   - out_valid = 1 for exactly NUM_DATA consecutive cycles.
//   - out_data = srt_dataout, out_id = index of g. out_last = 1 on cycle NUM_DATA.
//   - After the last cycle: grant = 0, rr_ptr = (g+1) mod NUM_REQ, go to IDLE.
//  Grant is held from IDLE exit until DRAIN or abort completes, even if req[g] drops.
//  in_valid from ungranted requesters is ignored.
//  Latency: the first out_valid comes exactly 1 cycle after srt_done is first seen high.
//  Idle gap between jobs: at least 2 cycles (IDLE, CLR).
//  Counters: cnt is $clog2(NUM_DATA)+1 bits and tcnt is $clog2(SORT_TIMEOUT)+1 bits; neither wraps.
// TESTING  (DATA_WIDTH=8, NUM_DATA=4, NUM_REQ=2, with a sorter model)
//  1. req = 01, data 9,3,7,1 -> grant = 01, CLR pulse, 4 writes, out 1,3,7,9; last on 9; out_id = 0.
//  2. req = 11 held over two jobs -> jobs go to requester 0 then 1; rr_ptr returns to 0.
//  3. Load with in_valid gaps (pattern 1,0,0,1,1,0,1) -> exactly 4 writes, no extra srt_wr_en.
//  4. Sorter model never raises done -> err pulses on SORT cycle 128, out_valid never 1, busy falls.
//  5. rst asserted in mid-DRAIN -> all outputs 0 asynchronously. After release, the next job starts with CLR.
//  6. req[g] dropped during LOAD -> job completes normally; the other requester's in_valid is ignored.

Source files
------------

// File: rtl/sort_arbiter_if.sv
// Requester-side bus of the sort arbiter: job requests, per-requester load streams
// and the single sorted output stream.
interface sort_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic [IDW-1:0]                out_id;

    modport slave (
        input  req, in_valid, in_data,
        output grant, in_ready, out_valid, out_data, out_last, out_id
    );

    modport master (
        output req, in_valid, in_data,
        input  grant, in_ready, out_valid, out_data, out_last, out_id
    );
endinterface

// File: rtl/sort_arbiter.sv
// Round-robin front end that shares one bubble-sort core among several requesters,
// walking each job through clear, load, sort and drain.
module sort_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_DATA     = 8,
    parameter int NUM_REQ      = 4,
    parameter int SORT_TIMEOUT = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_arbiter_if.slave         bus,
    output logic                  busy,
    output logic                  err,
    output logic                  srt_rst,
    output logic                  srt_wr_en,
    output logic [DATA_WIDTH-1:0] srt_datain,
    output logic                  srt_rd_en,
    input  logic [DATA_WIDTH-1:0] srt_dataout,
    input  logic                  srt_done
);
    localparam int IDW    = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(NUM_DATA) + 1;
    localparam int TCNT_W = $clog2(SORT_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_SORT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [NUM_REQ-1:0]  grant_q,     grant_d;
    logic [IDW-1:0]      gidx_q,      gidx_d;
    logic [IDW-1:0]      rr_q,        rr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [TCNT_W-1:0]   tcnt_q,      tcnt_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q,  out_last_d;
    logic                busy_q,      busy_d;

    logic [DATA_WIDTH-1:0] slice_s [NUM_REQ];
    logic [IDW-1:0]        pick_idx_s;
    logic [IDW-1:0]        next_rr_s;
    logic                  beat_s;
    logic                  timeout_s;

    // Unpack the flat load bus into one word per requester.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            slice_s[k] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick: walk downward so the requester closest above rr_q wins.
    always_comb begin
        logic [IDW-1:0] k_s;
        pick_idx_s = '0;
        k_s        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k_s        = IDW'((int'(rr_q) + i) % NUM_REQ);
            pick_idx_s = bus.req[k_s] ? k_s : pick_idx_s;
        end
    end

    // Strobes and the pointer value used when a job retires.
    always_comb begin
        beat_s    = (state_q == S_LOAD) && bus.in_valid[gidx_q];
        timeout_s = (state_q == S_SORT) && !srt_done
                    && (tcnt_q == TCNT_W'(SORT_TIMEOUT - 1));
        next_rr_s = (gidx_q == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : gidx_q + IDW'(1);
    end

    // Job sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    gidx_d  = pick_idx_s;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = S_CLR;
                end else begin
                    grant_d = '0;
                end
            end
            S_CLR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (beat_s && (cnt_q == CNT_W'(NUM_DATA - 1))) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = S_SORT;
                end else if (beat_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_SORT: begin
                // A done seen on the final allowed cycle still wins over the timeout.
                if (srt_done) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (timeout_s) begin
                    grant_d = '0;
                    rr_d    = next_rr_s;
                    tcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(NUM_DATA - 1)) begin
                    grant_d = '0;
                    rr_d    = next_rr_s;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        out_valid_d = (state_d == S_DRAIN);
        out_last_d  = (state_d == S_DRAIN) && (cnt_d == CNT_W'(NUM_DATA - 1));
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Sorter pins and requester-facing outputs; drain data is the sorter's own register.
    always_comb begin
        srt_rst       = rst || (state_q == S_CLR);
        srt_wr_en     = beat_s;
        srt_datain    = beat_s ? slice_s[gidx_q] : {DATA_WIDTH{1'b0}};
        srt_rd_en     = (state_q == S_SORT) && !srt_done;
        err           = timeout_s;
        busy          = busy_q;
        bus.grant     = grant_q;
        bus.in_ready  = (state_q == S_LOAD) ? grant_q : {NUM_REQ{1'b0}};
        bus.out_valid = out_valid_q;
        bus.out_data  = out_valid_q ? srt_dataout : {DATA_WIDTH{1'b0}};
        bus.out_last  = out_last_q;
        bus.out_id    = out_valid_q ? gidx_q : {IDW{1'b0}};
    end
endmodule

// File: tb/tb_sort_arbiter.sv
// Directed-plus-random bench for sort_arbiter with a behavioural bubble-sort core model.
module tb_sort_arbiter;
    localparam int DW = 8;
    localparam int ND = 4;
    localparam int NR = 2;
    localparam int TO = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    logic          busy, err, srt_rst, srt_wr_en, srt_rd_en, srt_done;
    logic [DW-1:0] srt_datain, srt_dataout;

    sort_arbiter #(.DATA_WIDTH(DW), .NUM_DATA(ND), .NUM_REQ(NR), .SORT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err),
        .srt_rst(srt_rst), .srt_wr_en(srt_wr_en), .srt_datain(srt_datain),
        .srt_rd_en(srt_rd_en), .srt_dataout(srt_dataout), .srt_done(srt_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int rr_m = 0;

    // Sorter model: stores written words, raises done after `need` steps, then streams sorted words.
    int            need = 3;
    bit            never_done = 1'b0;
    logic [DW-1:0] mem [ND];
    int            wcnt, steps, didx;
    logic          done_m;
    logic [DW-1:0] dout_m;
    assign srt_done    = done_m;
    assign srt_dataout = dout_m;

    function automatic logic [DW-1:0] kth(int k);
        logic [DW-1:0] a [ND];
        logic [DW-1:0] t;
        for (int i = 0; i < ND; i++) a[i] = mem[i];
        for (int i = 0; i < ND; i++)
            for (int j = 0; j < ND - 1; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[k];
    endfunction

    always @(posedge clk) begin
        if (srt_rst) begin
            wcnt <= 0; steps <= 0; didx <= 0; done_m <= 1'b0; dout_m <= '0;
        end else begin
            if (srt_wr_en && wcnt < ND) begin mem[wcnt] <= srt_datain; wcnt <= wcnt + 1; end
            if (srt_rd_en) begin
                steps <= steps + 1;
                if (!never_done && steps + 1 >= need) done_m <= 1'b1;
            end
            if (done_m && didx < ND) begin dout_m <= kth(didx); didx <= didx + 1; end
        end
    end

    int wr_cnt = 0;
    int ov_cnt = 0;
    always @(posedge clk) if (srt_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
    always @(negedge clk) if (bus.out_valid === 1'b1) ov_cnt <= ov_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gap_mode: 0 = no gaps, 1 = fixed 1,0,0,1,1,0,1 pattern, 2 = random gaps.
    task automatic run_job(input logic [NR-1:0] reqv, input logic [ND*DW-1:0] dpk,
                           input int gap_mode, input bit drop, input bit tmo, input bit rst_mid);
        int owner, other, w, cyc, pi, sc, dseen, wr0, ov0;
        bit v;
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] exp_q [$];
        owner = -1;
        for (int i = 0; i < NR; i++)
            if (owner < 0 && reqv[(rr_m + i) % NR]) owner = (rr_m + i) % NR;
        other = 1 - owner;
        never_done = tmo;
        need = $urandom_range(1, 6);
        wr0 = wr_cnt;
        ov0 = ov_cnt;
        bus.req = reqv;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus.grant === '0 && cyc < 20);
        check("grant", 32'(bus.grant), 32'(1 << owner));
        check("clr_pulse", 32'(srt_rst), 32'd1);
        check("busy_job", 32'(busy), 32'd1);

        w = 0; cyc = 0; pi = 0;
        while (w < ND && cyc < 100) begin
            v = 1'b1;
            if (gap_mode == 1) v = pat[pi];
            else if (gap_mode == 2) v = ($urandom_range(0, 2) != 0);
            bus.in_valid[owner] = v;
            bus.in_valid[other] = 1'b1;
            bus.in_data[owner*DW +: DW] = dpk[w*DW +: DW];
            bus.in_data[other*DW +: DW] = DW'($urandom);
            #1;
            check("in_ready_other", 32'(bus.in_ready[other]), 32'd0);
            if (bus.in_ready[owner] === 1'b1) begin
                check("wr_en", 32'(srt_wr_en), 32'(v));
                if (v) begin
                    check("wr_data", 32'(srt_datain), 32'(dpk[w*DW +: DW]));
                    w++;
                end
                if (pi < 6) pi++;
            end else begin
                check("wr_en_idle", 32'(srt_wr_en), 32'd0);
            end
            if (drop && w == 1) bus.req[owner] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = '0;
        check("load_words", 32'(w), 32'(ND));
        check("wr_count", 32'(wr_cnt - wr0), 32'(ND));
        check("grant_held", 32'(bus.grant), 32'(1 << owner));

        if (tmo) begin
            sc = 1;
            while (err !== 1'b1 && sc < 200) begin @(negedge clk); sc++; end
            check("timeout_cycle", 32'(sc), 32'(TO));
            @(negedge clk);
            #1;
            check("busy_after_tmo", 32'(busy), 32'd0);
            check("grant_after_tmo", 32'(bus.grant), 32'd0);
            check("no_output_tmo", 32'(ov_cnt - ov0), 32'd0);
            rr_m = (owner + 1) % NR;
            return;
        end

        for (int i = 0; i < ND; i++) exp_q.push_back(dpk[i*DW +: DW]);
        exp_q.sort();
        dseen = -1; cyc = 0;
        check("rd_en_sort", 32'(srt_rd_en), 32'd1);
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            if (srt_done === 1'b1 && dseen < 0) dseen = cyc;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc - dseen), 32'd1);
        for (int i = 0; i < ND; i++) begin
            if (rst_mid && i == 2) begin
                bus.req = '0;
                rst = 1'b1;
                #1;
                check("rst_out_valid", 32'(bus.out_valid), 32'd0);
                check("rst_outputs", {bus.grant, bus.in_ready, busy, err, srt_wr_en, srt_rd_en,
                                      bus.out_last, 24'(bus.out_data)}, 32'd0);
                check("rst_srt_rst", 32'(srt_rst), 32'd1);
                @(negedge clk);
                rst = 1'b0;
                rr_m = 0;
                @(negedge clk);
                check("post_rst_idle", {30'd0, bus.out_valid, busy}, 32'd0);
                return;
            end
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_data", 32'(bus.out_data), 32'(exp_q[i]));
            check("out_last", 32'(bus.out_last), 32'(i == ND - 1));
            check("out_id", 32'(bus.out_id), 32'(owner));
            @(negedge clk);
        end
        check("drain_end", 32'(bus.out_valid), 32'd0);
        check("grant_release", 32'(bus.grant), 32'd0);
        rr_m = (owner + 1) % NR;
    endtask

    initial begin
        logic [NR-1:0] rq;
        rst = 1'b1;
        bus.req = '0;
        bus.in_valid = '0;
        bus.in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_misc", {bus.in_ready, busy, err, srt_wr_en, srt_rd_en, bus.out_valid,
                             bus.out_last, 22'(bus.out_data)}, 32'd0);
        check("reset_srt_rst", 32'(srt_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("srt_rst_release", 32'(srt_rst), 32'd0);

        run_job(2'b01, {8'd1, 8'd7, 8'd3, 8'd9}, 0, 1'b0, 1'b0, 1'b0);
        run_job(2'b11, $urandom, 0, 1'b0, 1'b0, 1'b0);
        run_job(2'b11, $urandom, 0, 1'b0, 1'b0, 1'b0);
        run_job(2'b01, $urandom, 1, 1'b0, 1'b0, 1'b0);
        run_job(2'b10, $urandom, 0, 1'b0, 1'b1, 1'b0);
        run_job(2'b10, $urandom, 2, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            rq = NR'($urandom_range(1, 3));
            run_job(rq, $urandom, 2, 1'b0, 1'b0, 1'b0);
        end
        run_job(2'b11, $urandom, 0, 1'b0, 1'b0, 1'b1);
        run_job(2'b10, $urandom, 2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
